// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The misaligned-redirect trap is selected in fetch_unit by FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } iq_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_iq.sv
// Synchronous FIFO with occupancy count and a flush that empties it in one edge.
// Used both as the instruction queue and as the in-flight request address queue.
module fetch_iq #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    // Empty queue presents zeros so consumers never see stale storage.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues imem requests from the PC, queues in-order responses for decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects instead of word-aligning them.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int IQ_DEPTH        = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    output logic            pc_write_en,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic            fetch_fault
);

    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int ICW = $clog2(IQ_DEPTH + 1);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [OCW-1:0]  outstanding;
    logic [OCW-1:0]  drop_cnt;
    logic [OCW-1:0]  drop_next;
    logic [ICW-1:0]  iq_count;
    logic [XLEN-1:0] infl_addr;
    iq_entry_t       iq_head;
    logic            req_fire;
    logic            rsp_accept;
    logic            redirect_take;
    logic            misaligned;
    logic [XLEN-1:0] redirect_target;
    logic            iq_push;
    logic            iq_pop;
    logic            iq_flush;

    assign redirect_take = redirect_valid && (state != IDLE);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
    assign fetch_fault     = redirect_take && misaligned;
`else
    assign misaligned      = 1'b0;
    assign redirect_target = word_align(redirect_pc);
    assign fetch_fault     = 1'b0;
`endif

    // Credits count both in-flight requests and queued entries so the IQ can never overflow.
    assign imem_req_valid = (state == RUN)
                         && ((int'(outstanding) + int'(iq_count)) < IQ_DEPTH)
                         && (int'(outstanding) < MAX_OUTSTANDING)
                         && !redirect_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_accept     = imem_rsp_valid && (outstanding != '0);

    assign pc_write_en = redirect_take || req_fire;
    assign pc_next     = redirect_take ? redirect_target : pc + PC_STEP;

    assign dec_valid = (iq_count != '0);
    assign dec_pc    = iq_head.pc;
    assign dec_instr = iq_head.instr;
    assign iq_pop    = dec_valid && dec_ready && !redirect_take;

    fetch_iq #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (XLEN)
    ) u_inflight (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_accept),
        .head      (infl_addr),
        .count     (outstanding)
    );

    fetch_iq #(
        .DEPTH (IQ_DEPTH),
        .WIDTH ($bits(iq_entry_t))
    ) u_iq (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (iq_flush),
        .push      (iq_push),
        .push_data ({infl_addr, imem_rsp_data}),
        .pop       (iq_pop),
        .head      (iq_head),
        .count     (iq_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_next;
        end
    end

    // drop_cnt tracks responses still owed for requests issued before the last redirect.
    always_comb begin
        state_next = state;
        drop_next  = drop_cnt;
        iq_push    = 1'b0;
        iq_flush   = 1'b0;
        case (state)
            IDLE: state_next = RUN;
            RUN: begin
                if (redirect_take) begin
                    iq_flush   = 1'b1;
                    drop_next  = outstanding - OCW'(rsp_accept);
                    if (misaligned)             state_next = HALT;
                    else if (drop_next != '0)   state_next = FLUSH;
                    else                        state_next = RUN;
                end else begin
                    iq_push = rsp_accept;
                end
            end
            FLUSH, HALT: begin
                if (rsp_accept) drop_next = drop_cnt - 1'b1;
                if (redirect_take) begin
                    iq_flush = 1'b1;
                    if (misaligned)             state_next = HALT;
                    else if (drop_next != '0)   state_next = FLUSH;
                    else                        state_next = RUN;
                end else if ((state == FLUSH) && (drop_next == '0)) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a queue model.
// Honours FETCH_MISALIGN_TRAP_EN the same way the design does.
module tb_fetch_unit;

    localparam int IQ_DEPTH = 2;
    localparam int MAX_OUT  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_write_en;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        fetch_fault;

    always #5 clk = ~clk;

    fetch_unit #(
        .IQ_DEPTH        (IQ_DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .pc_write_en    (pc_write_en),
        .pc_next        (pc_next),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fetch_fault    (fetch_fault)
    );

    typedef struct { logic [31:0] addr; bit stale; } infl_t;
    typedef struct { logic [31:0] addr; int t; } memreq_t;

    // Model: in-flight requests (stale once a redirect passed them), decode queue, external PC.
    infl_t       infl[$];
    logic [31:0] iq_pc[$];
    logic [31:0] iq_ins[$];
    logic [31:0] m_pc;
    bit          m_idle;
    bit          m_halted;

    memreq_t     mem_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] ins_log[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit          rst_drive;
    int          lat, rsp_pct, rdy_pct, drdy_pct, redir_pct;
    bit          stray_en;
    bit          redir_req;
    logic [31:0] redir_target;

    bit          exp_req, exp_fire, exp_wen, exp_dv, exp_fault;
    logic [31:0] exp_pcn;

    function automatic logic [31:0] alignT(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
        return a;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    function automatic logic [31:0] randTarget();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 255)) << 2;
            1:       return 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            2:       return 32'($urandom_range(0, 1023));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    task automatic pinLog(input string name, input logic [31:0] q[$], input int idx,
                          input logic [31:0] expv);
        if (idx < q.size()) checkVal(name, q[idx], expv);
        else begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: entry %0d missing (%0d logged) expected %h",
                     name, idx, q.size(), expv);
        end
    endtask

    task automatic modelReset();
        infl.delete();
        iq_pc.delete();
        iq_ins.delete();
        m_pc     = 32'h0;
        m_idle   = 1'b1;
        m_halted = 1'b0;
    endtask

    // Drives one cycle of inputs; the memory answers in order after at least lat cycles.
    task automatic applyStimulus();
        cyc++;
        rst_n = rst_drive;
        if (!rst_n) modelReset();
        imem_req_ready = int'($urandom_range(0, 99)) < rdy_pct;
        dec_ready      = int'($urandom_range(0, 99)) < drdy_pct;
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (rst_n && !m_idle) begin
            if (redir_req) begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_target;
                redir_req      = 1'b0;
            end else if (int'($urandom_range(0, 99)) < redir_pct) begin
                redirect_valid = 1'b1;
                redirect_pc    = randTarget();
            end
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_q.size() > 0) begin
            if (!rst_n || m_idle ||
                ((cyc - mem_q[0].t >= lat) && int'($urandom_range(0, 99)) < rsp_pct)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~mem_q[0].addr;
                void'(mem_q.pop_front());
            end
        end else if (stray_en && $urandom_range(0, 99) < 4) begin
            imem_rsp_valid = 1'b1;
        end
        pc = m_pc;
    endtask

    task automatic checkOutput();
        int stale_n;
        bit active;
        bit run;
        stale_n = 0;
        foreach (infl[i]) if (infl[i].stale) stale_n++;
        active    = rst_n && !m_idle;
        run       = active && !m_halted && (stale_n == 0);
        exp_req   = run && (infl.size() + iq_pc.size() < IQ_DEPTH) && (infl.size() < MAX_OUT)
                    && !redirect_valid;
        exp_fire  = exp_req && imem_req_ready;
        exp_wen   = (active && redirect_valid) || exp_fire;
        exp_pcn   = redirect_valid ? alignT(redirect_pc) : m_pc + 32'd4;
        exp_dv    = (iq_pc.size() > 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_fault = active && redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
        exp_fault = 1'b0;
`endif
        checkVal("imem_req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) checkVal("imem_req_addr", imem_req_addr, m_pc);
        checkVal("pc_write_en", 32'(pc_write_en), 32'(exp_wen));
        if (exp_wen) checkVal("pc_next", pc_next, exp_pcn);
        checkVal("dec_valid", 32'(dec_valid), 32'(exp_dv));
        if (exp_dv) begin
            checkVal("dec_pc", dec_pc, iq_pc[0]);
            checkVal("dec_instr", dec_instr, iq_ins[0]);
        end else if (!rst_n) begin
            checkVal("reset_dec_pc", dec_pc, 32'h0);
            checkVal("reset_dec_instr", dec_instr, 32'h0);
        end
        checkVal("fetch_fault", 32'(fetch_fault), 32'(exp_fault));
    endtask

    task automatic modelAdvance();
        infl_t e;
        bit    rsp_acc;
        if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
        if (dec_valid && dec_ready && !redirect_valid) begin
            pop_log.push_back(dec_pc);
            ins_log.push_back(dec_instr);
        end
        if (!rst_n) return;
        if (m_idle) begin
            m_idle = 1'b0;
            mem_q.delete();
            return;
        end
        rsp_acc = imem_rsp_valid && (infl.size() > 0);
        if (rsp_acc) e = infl.pop_front();
        if (redirect_valid) begin
            iq_pc.delete();
            iq_ins.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_halted = (redirect_pc[1:0] != 2'b00);
`endif
        end else begin
            if (exp_dv && dec_ready) begin
                void'(iq_pc.pop_front());
                void'(iq_ins.pop_front());
            end
            if (rsp_acc && !e.stale) begin
                iq_pc.push_back(e.addr);
                iq_ins.push_back(imem_rsp_data);
            end
        end
        if (exp_fire) infl.push_back('{addr: m_pc, stale: 1'b0});
        if (exp_wen) m_pc = exp_pcn;
        if (imem_req_valid && imem_req_ready) mem_q.push_back('{addr: imem_req_addr, t: cyc});
    endtask

    task automatic step();
        @(negedge clk);
        applyStimulus();
        #1;
        checkOutput();
        modelAdvance();
    endtask

    task automatic doReset();
        rst_drive = 1'b0;
        repeat (2) step();
        rst_drive = 1'b1;
        step();
    endtask

    task automatic waitFire(input string name, input int budget, input logic [31:0] addr,
                            output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (imem_req_valid && imem_req_ready) seen = 1'b1;
        end
        checkVal({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) checkVal({name, "_addr"}, imem_req_addr, addr);
    endtask

    task automatic directedCfg(input int latency);
        lat = latency; rsp_pct = 100; rdy_pct = 100; drdy_pct = 100;
        redir_pct = 0; stray_en = 1'b0; redir_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        int n0;
        rst_n = 1'b0; rst_drive = 1'b0; pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0; redir_target = '0;
        modelReset();
        directedCfg(1);

        // Reset values and the first in-order fetch sequence.
        repeat (3) step();
        checkVal("rst_imem_req_valid", 32'(imem_req_valid), 32'd0);
        checkVal("rst_pc_write_en", 32'(pc_write_en), 32'd0);
        req_log.delete(); pop_log.delete(); ins_log.delete();
        rst_drive = 1'b1;
        repeat (12) step();
        pinLog("seq_req0", req_log, 0, 32'h0);
        pinLog("seq_req1", req_log, 1, 32'h4);
        pinLog("seq_req2", req_log, 2, 32'h8);
        pinLog("seq_pop0", pop_log, 0, 32'h0);
        pinLog("seq_pop1", pop_log, 1, 32'h4);
        pinLog("seq_pop2", pop_log, 2, 32'h8);
        pinLog("seq_ins0", ins_log, 0, 32'hFFFF_FFFF);
        pinLog("seq_ins2", ins_log, 2, 32'hFFFF_FFF7);

        // Decode stall: credits cap issued requests and nothing is lost afterwards.
        drdy_pct = 0;
        n0 = req_log.size();
        repeat (10) step();
        checkVal("stall_reqs_le_depth", 32'(req_log.size() - n0 <= IQ_DEPTH), 32'd1);
        checkVal("stall_req_valid", 32'(imem_req_valid), 32'd0);
        checkVal("stall_dec_valid", 32'(dec_valid), 32'd1);
        drdy_pct = 100;
        repeat (10) step();

        // Redirect with two requests in flight: both responses are dropped.
        directedCfg(3);
        doReset();
        repeat (2) step();
        pop_log.delete();
        redir_req = 1'b1; redir_target = 32'h100;
        step();
        checkVal("redir_pc_write_en", 32'(pc_write_en), 32'd1);
        checkVal("redir_pc_next", pc_next, 32'h100);
        for (int i = 0; i < 30 && pop_log.size() == 0; i++) step();
        pinLog("redir_first_pop", pop_log, 0, 32'h100);

        // PC wrap at the top of the address space.
        directedCfg(1);
        redir_req = 1'b1; redir_target = 32'hFFFF_FFFC;
        step();
        waitFire("wrap", 20, 32'hFFFF_FFFC, seen);
        if (seen) checkVal("wrap_pc_next", pc_next, 32'h0);
        waitFire("wrap_next", 20, 32'h0, seen);

        // Misaligned redirect.
        redir_req = 1'b1; redir_target = 32'h102;
        step();
`ifdef FETCH_MISALIGN_TRAP_EN
        checkVal("misalign_fault", 32'(fetch_fault), 32'd1);
        checkVal("misalign_pc_next", pc_next, 32'h102);
        n0 = req_log.size();
        repeat (8) step();
        checkVal("halt_no_reqs", 32'(req_log.size() - n0), 32'd0);
        redir_req = 1'b1; redir_target = 32'h200;
        step();
        waitFire("halt_exit", 20, 32'h200, seen);
`else
        checkVal("misalign_fault", 32'(fetch_fault), 32'd0);
        checkVal("misalign_pc_next", pc_next, 32'h100);
        waitFire("misalign", 20, 32'h100, seen);
`endif

        // Reset mid-transaction; late responses arrive during reset and idle.
        directedCfg(2);
        drdy_pct = 0;
        doReset();
        repeat (2) step();
        rst_drive = 1'b0;
        step();
        checkVal("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        checkVal("midrst_pc_write_en", 32'(pc_write_en), 32'd0);
        checkVal("midrst_dec_valid", 32'(dec_valid), 32'd0);
        checkVal("midrst_fault", 32'(fetch_fault), 32'd0);
        rst_drive = 1'b1;
        drdy_pct = 100;
        waitFire("restart", 10, 32'h0, seen);

        // Randomized traffic with redirects, stray responses and one reset.
        lat = 1; rsp_pct = 60; rdy_pct = 70; drdy_pct = 60; redir_pct = 4; stray_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) rst_drive = 1'b0;
            if (c == 1502) rst_drive = 1'b1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
